// File: rtl/game_ctrl_pkg.sv
// rtl/game_ctrl_pkg.sv - shared tile codes and game state encoding for the collision controller
package game_ctrl_pkg;

   localparam logic [1:0] TILE_BACKGROUND = 2'b00;
   localparam logic [1:0] TILE_FLOOR      = 2'b01;
   localparam logic [1:0] TILE_GIFT       = 2'b10;
   localparam logic [1:0] TILE_HOLE       = 2'b11;

   typedef enum logic [1:0] {
      PLAYING   = 2'd0,
      HOLE_OPEN = 2'd1,
      VICTORY   = 2'd2,
      GAME_OVER = 2'd3
   } game_state_t;

endpackage

// File: rtl/frame_once_pulse.sv
// rtl/frame_once_pulse.sv - once-per-frame event detector with registered one-cycle pulse
module frame_once_pulse (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic event_i,
   output logic first_o,
   output logic pulse_o
);

   logic flag_q;
   logic flag_d;
   logic pulse_q;

   // A clear in the same cycle as the event starts the new frame with this event.
   assign first_o = event_i & (clear_i | ~flag_q);
   assign flag_d  = clear_i ? event_i : (flag_q | event_i);

   always_ff @(posedge clk) begin
      if (reset) begin
         flag_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         flag_q  <= flag_d;
         pulse_q <= first_o;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/game_collision_ctrl.sv
// rtl/game_collision_ctrl.sv - per-pixel collision detection, gift/lives bookkeeping and game FSM
module game_collision_ctrl
   import game_ctrl_pkg::*;
#(
   parameter int NUM_ENEMIES  = 4,
   parameter int GIFT_QUOTA   = 8,
   parameter int LIVES        = 3,
   parameter int GRACE_FRAMES = 30
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start_of_frame,
   input  logic                   draw_req_ball,
   input  logic                   draw_req_tile,
   input  logic                   draw_req_border,
   input  logic [1:0]             tile_type,
   input  logic [NUM_ENEMIES-1:0] draw_req_enemy,
   input  logic                   restart,
   output logic                   collision,
   output logic                   single_hit_pulse,
   output logic                   gift_write_en,
   output logic [NUM_ENEMIES-1:0] enemy_hit,
   output logic [7:0]             gifts_left,
   output logic [3:0]             lives_left,
   output logic                   hole_open,
   output logic                   endgame,
   output logic                   victory
);

   game_state_t state_q;
   logic [7:0]  gifts_left_q;
   logic [3:0]  lives_q;
   logic [7:0]  grace_q;
   logic        collision_q;

   logic                   clear;
   logic                   active;
   logic                   ball_tile;
   logic                   wall_ev;
   logic                   gift_ev;
   logic                   hole_entry;
   logic                   enemy_acc;
   logic [NUM_ENEMIES-1:0] enemy_ev;
   logic [NUM_ENEMIES-1:0] enemy_first;
   logic                   gift_first;
   logic                   wall_first_unused;

   assign clear     = start_of_frame | restart;
   assign active    = (state_q == PLAYING) || (state_q == HOLE_OPEN);
   assign ball_tile = draw_req_ball & draw_req_tile;

   // The hole tile behaves like a wall until the hole has been opened.
   assign wall_ev = ~restart & draw_req_ball &
                    (draw_req_border |
                     (draw_req_tile & (tile_type == TILE_FLOOR)) |
                     (draw_req_tile & (tile_type == TILE_HOLE) & (state_q != HOLE_OPEN)));
   assign gift_ev    = ~restart & active & ball_tile & (tile_type == TILE_GIFT);
   assign enemy_ev   = (restart || !draw_req_ball) ? '0 : draw_req_enemy;
   assign hole_entry = (state_q == HOLE_OPEN) & ball_tile & (tile_type == TILE_HOLE);
   assign enemy_acc  = (|enemy_first) & (grace_q == 8'd0) & active;

   frame_once_pulse u_wall (
      .clk(clk), .reset(reset), .clear_i(clear), .event_i(wall_ev),
      .first_o(wall_first_unused), .pulse_o(single_hit_pulse)
   );

   frame_once_pulse u_gift (
      .clk(clk), .reset(reset), .clear_i(clear), .event_i(gift_ev),
      .first_o(gift_first), .pulse_o(gift_write_en)
   );

   for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_enemy
      frame_once_pulse u_enemy (
         .clk(clk), .reset(reset), .clear_i(clear), .event_i(enemy_ev[i]),
         .first_o(enemy_first[i]), .pulse_o(enemy_hit[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset || restart) begin
         state_q      <= PLAYING;
         gifts_left_q <= 8'(GIFT_QUOTA);
         lives_q      <= 4'(LIVES);
         grace_q      <= 8'd0;
         collision_q  <= 1'b0;
      end else begin
         collision_q <= wall_ev;

         if (gift_first && (gifts_left_q != 8'd0))
            gifts_left_q <= gifts_left_q - 8'd1;

         // Reaching the hole outranks a simultaneous enemy hit: no life is taken.
         if (enemy_acc && !hole_entry) begin
            lives_q <= lives_q - 4'd1;
            grace_q <= 8'(GRACE_FRAMES);
         end else if (start_of_frame && (grace_q != 8'd0)) begin
            grace_q <= grace_q - 8'd1;
         end

         case (state_q)
            PLAYING: begin
               if (enemy_acc && (lives_q == 4'd1))
                  state_q <= GAME_OVER;
               else if (gifts_left_q == 8'd0)
                  state_q <= HOLE_OPEN;
            end
            HOLE_OPEN: begin
               if (hole_entry)
                  state_q <= VICTORY;
               else if (enemy_acc && (lives_q == 4'd1))
                  state_q <= GAME_OVER;
            end
            default: state_q <= state_q;
         endcase
      end
   end

   assign collision  = collision_q;
   assign gifts_left = gifts_left_q;
   assign lives_left = lives_q;
   assign hole_open  = (state_q == HOLE_OPEN);
   assign endgame    = (state_q == VICTORY) || (state_q == GAME_OVER);
   assign victory    = (state_q == VICTORY);

endmodule

// File: tb/tb_game_collision_ctrl.sv
// tb/tb_game_collision_ctrl.sv - directed vector bench for game_collision_ctrl
module tb_game_collision_ctrl;

   localparam int NE = 4;

   logic          clk = 1'b0;
   logic          reset, start_of_frame, draw_req_ball, draw_req_tile, draw_req_border, restart;
   logic [1:0]    tile_type;
   logic [NE-1:0] draw_req_enemy;
   logic          collision, single_hit_pulse, gift_write_en;
   logic [NE-1:0] enemy_hit;
   logic [7:0]    gifts_left;
   logic [3:0]    lives_left;
   logic          hole_open, endgame, victory;

   always #5 clk = ~clk;

   game_collision_ctrl #(
      .NUM_ENEMIES(NE), .GIFT_QUOTA(2), .LIVES(2), .GRACE_FRAMES(3)
   ) dut (
      .clk(clk), .reset(reset), .start_of_frame(start_of_frame),
      .draw_req_ball(draw_req_ball), .draw_req_tile(draw_req_tile),
      .draw_req_border(draw_req_border), .tile_type(tile_type),
      .draw_req_enemy(draw_req_enemy), .restart(restart),
      .collision(collision), .single_hit_pulse(single_hit_pulse),
      .gift_write_en(gift_write_en), .enemy_hit(enemy_hit),
      .gifts_left(gifts_left), .lives_left(lives_left),
      .hole_open(hole_open), .endgame(endgame), .victory(victory)
   );

   typedef struct {
      string       name;
      logic [11:0] in;
      logic [21:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   checks   = 0;
   int   failures = 0;

   wire [21:0] outv = {collision, single_hit_pulse, gift_write_en, enemy_hit,
                       gifts_left, lives_left, hole_open, endgame, victory};

   function automatic logic [11:0] mi(bit rst, bit rs, bit sof, bit b, bit t, bit bd,
                                      logic [1:0] tt, logic [3:0] en);
      return {rst, rs, sof, b, t, bd, tt, en};
   endfunction

   function automatic logic [21:0] mo(bit c, bit s, bit g, logic [3:0] eh, logic [7:0] gl,
                                      logic [3:0] ll, bit ho, bit eg, bit v);
      return {c, s, g, eh, gl, ll, ho, eg, v};
   endfunction

   task automatic add(string n, logic [11:0] i, logic [21:0] e);
      vec_t x;
      x.name = n;
      x.in   = i;
      x.exp  = e;
      tbl.push_back(x);
   endtask

   task automatic apply(logic [11:0] i);
      {reset, restart, start_of_frame, draw_req_ball, draw_req_tile, draw_req_border,
       tile_type, draw_req_enemy} = i;
      @(posedge clk);
      #1;
   endtask

   task automatic check(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", n, act, exp);
      end
   endtask

   int ncol, nshp, nshp_total;

   initial begin
      // tile codes: 1 floor, 2 gift, 3 hole
      add("reset",             mi(1,0,0,0,0,0,0,0),     mo(0,0,0,0,2,2,0,0,0));
      add("idle",              mi(0,0,0,0,0,0,0,0),     mo(0,0,0,0,2,2,0,0,0));
      add("floor_first",       mi(0,0,1,1,1,0,1,0),     mo(1,1,0,0,2,2,0,0,0));
      add("floor_again",       mi(0,0,0,1,1,0,1,0),     mo(1,0,0,0,2,2,0,0,0));
      add("border",            mi(0,0,0,1,0,1,0,0),     mo(1,0,0,0,2,2,0,0,0));
      add("idle2",             mi(0,0,0,0,0,0,0,0),     mo(0,0,0,0,2,2,0,0,0));
      add("sof_wall_same",     mi(0,0,1,1,1,0,1,0),     mo(1,1,0,0,2,2,0,0,0));
      add("sof",               mi(0,0,1,0,0,0,0,0),     mo(0,0,0,0,2,2,0,0,0));
      add("gift1",             mi(0,0,0,1,1,0,2,0),     mo(0,0,1,0,1,2,0,0,0));
      add("gift_dup",          mi(0,0,0,1,1,0,2,0),     mo(0,0,0,0,1,2,0,0,0));
      add("hole_closed",       mi(0,0,1,1,1,0,3,0),     mo(1,1,0,0,1,2,0,0,0));
      add("gift2",             mi(0,0,1,1,1,0,2,0),     mo(0,0,1,0,0,2,0,0,0));
      add("hole_opens",        mi(0,0,0,0,0,0,0,0),     mo(0,0,0,0,0,2,1,0,0));
      add("gift3_sat",         mi(0,0,1,1,1,0,2,0),     mo(0,0,1,0,0,2,1,0,0));
      add("enemy_0_2",         mi(0,0,0,1,0,0,0,4'b0101), mo(0,0,0,4'b0101,0,1,1,0,0));
      add("enemy_dup",         mi(0,0,0,1,0,0,0,4'b0101), mo(0,0,0,4'b0000,0,1,1,0,0));
      add("sof_g2",            mi(0,0,1,0,0,0,0,0),     mo(0,0,0,0,0,1,1,0,0));
      add("enemy_in_grace",    mi(0,0,1,1,0,0,0,4'b0001), mo(0,0,0,4'b0001,0,1,1,0,0));
      add("sof_g0",            mi(0,0,1,0,0,0,0,0),     mo(0,0,0,0,0,1,1,0,0));
      add("enemy_game_over",   mi(0,0,1,1,0,0,0,4'b0010), mo(0,0,0,4'b0010,0,0,0,1,0));
      add("go_wall",           mi(0,0,0,1,1,0,1,0),     mo(1,1,0,0,0,0,0,1,0));
      add("go_gift_frozen",    mi(0,0,0,1,1,0,2,0),     mo(0,0,0,0,0,0,0,1,0));
      add("restart",           mi(0,1,0,0,0,0,0,0),     mo(0,0,0,0,2,2,0,0,0));
      add("restart_priority",  mi(0,1,1,1,1,0,1,4'b1111), mo(0,0,0,0,2,2,0,0,0));
      add("wall_after_restart", mi(0,0,0,1,1,0,1,0),    mo(1,1,0,0,2,2,0,0,0));
      add("gift_a",            mi(0,0,1,1,1,0,2,0),     mo(0,0,1,0,1,2,0,0,0));
      add("gift_b",            mi(0,0,1,1,1,0,2,0),     mo(0,0,1,0,0,2,0,0,0));
      add("hole_at_t",         mi(0,0,0,1,1,0,3,0),     mo(1,1,0,0,0,2,1,0,0));
      add("victory_over_hit",  mi(0,0,0,1,1,0,3,4'b0001), mo(0,0,0,4'b0001,0,2,0,1,1));
      add("victory_enemy",     mi(0,0,0,1,0,0,0,4'b1000), mo(0,0,0,4'b1000,0,2,0,1,1));
      add("reset_mid",         mi(1,0,0,1,1,0,1,0),     mo(0,0,0,0,2,2,0,0,0));
      add("wall_after_reset",  mi(0,0,0,1,1,0,1,0),     mo(1,1,0,0,2,2,0,0,0));

      for (int k = 0; k < tbl.size(); k++) begin
         apply(tbl[k].in);
         check(tbl[k].name, 32'(outv), 32'(tbl[k].exp));
      end

      // Two frames of 50 floor pixels each.
      nshp_total = 0;
      for (int f = 0; f < 2; f++) begin
         ncol = 0;
         nshp = 0;
         apply(mi(0,0,1,0,0,0,0,0));
         for (int p = 0; p < 50; p++) begin
            apply(mi(0,0,0,1,1,0,1,0));
            ncol += int'(collision);
            nshp += int'(single_hit_pulse);
         end
         apply(mi(0,0,0,0,0,0,0,0));
         ncol += int'(collision);
         nshp += int'(single_hit_pulse);
         check($sformatf("frame%0d_collision_cycles", f), 32'(ncol), 32'd50);
         check($sformatf("frame%0d_hit_pulses", f), 32'(nshp), 32'd1);
         nshp_total += nshp;
      end
      check("total_hit_pulses", 32'(nshp_total), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
